event_irq_ctrl: RTL and testbench

- APB slave that collects NUM_SRC peripheral event/interrupt sources and feeds the sleep controller's irq_i/event_i inputs and the core's interrupt inputs.
- Rising-edge capture of each source into sticky pending registers.
- Per-source IRQ and event masking; an irq_id_o priority encoder for the core; hardware acknowledge and software clear.

---
 rtl/event_irq_pkg.sv | 27 ++
 rtl/event_irq_ctrl_if.sv | 23 ++
 rtl/event_edge_capture.sv | 43 ++++
 rtl/event_irq_ctrl.sv | 100 ++++++++++
 tb/tb_event_irq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/event_irq_pkg.sv
// Shared register indices, source-count limit and priority helper for event_irq_ctrl.
package event_irq_pkg;

   localparam int unsigned NUM_SRC_MAX = 32;

   typedef enum logic [2:0] {
      REG_IER  = 3'd0,
      REG_IPR  = 3'd1,
      REG_ICP  = 3'd2,
      REG_EER  = 3'd3,
      REG_EPR  = 3'd4,
      REG_ECP  = 3'd5,
      REG_RSV6 = 3'd6,
      REG_RSV7 = 3'd7
   } reg_idx_e;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int unsigned i = NUM_SRC_MAX; i > 0; i--) begin
         if (vec[i-1]) idx = 5'(i - 1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/event_irq_ctrl_if.sv
// APB slave bus bundle for event_irq_ctrl.
interface event_irq_ctrl_if #(
   parameter int APB_ADDR_WIDTH = 12
) ();
   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [31:0]               PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic [31:0]               PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/event_edge_capture.sv
// Rising-edge detector for the source lines; EVENT_IRQ_SYNC_EN inserts a
// 2-flop synchroniser ahead of the edge register for asynchronous sources.
module event_edge_capture
   import event_irq_pkg::*;
#(
   parameter int NUM_SRC = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_i,
   output logic [NUM_SRC-1:0] edge_o
);

   logic [NUM_SRC-1:0] src_s;
   logic [NUM_SRC-1:0] src_q;

`ifdef EVENT_IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync_1;
   logic [NUM_SRC-1:0] sync_2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= src_i;
         sync_2 <= sync_1;
      end
   end

   assign src_s = sync_2;
`else
   assign src_s = src_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) src_q <= '0;
      else     src_q <= src_s;
   end

   assign edge_o = src_s & ~src_q;

endmodule

// File: rtl/event_irq_ctrl.sv
// APB event/interrupt controller: sticky edge-captured pending bits, per-source
// IRQ/event masks, lowest-index priority encoder. Optional macro: EVENT_IRQ_SYNC_EN.
module event_irq_ctrl
   import event_irq_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_SRC        = 32
) (
   input  logic               HCLK,
   input  logic               HRESET,
   event_irq_ctrl_if.slave    apb,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               irq_ack_i,
   input  logic [4:0]         irq_ack_id_i,
   output logic               irq_o,
   output logic [4:0]         irq_id_o,
   output logic               event_o
);

   localparam logic [31:0] SRC_MASK = 32'hFFFF_FFFF >> (NUM_SRC_MAX - NUM_SRC);

   logic [31:0] ier, ipr, eer, epr;
   logic [31:0] ipr_nxt, epr_nxt;
   logic [31:0] edge_vec, wdata, ack_mask, rdata;
   logic [NUM_SRC-1:0] src_edge;
   logic [APB_ADDR_WIDTH-1:0] paddr;
   reg_idx_e reg_idx;
   logic wr_en, rd_en;
   logic unused_addr;

   assign paddr       = apb.PADDR;
   assign reg_idx     = reg_idx_e'(paddr[4:2]);
   assign unused_addr = ^{paddr[APB_ADDR_WIDTH-1:5], paddr[1:0]};
   assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign rd_en       = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
   assign wdata       = apb.PWDATA & SRC_MASK;

   event_edge_capture #(.NUM_SRC(NUM_SRC)) u_edge (
      .clk    (HCLK),
      .rst    (HRESET),
      .src_i  (src_i),
      .edge_o (src_edge)
   );

   always_comb begin
      edge_vec = '0;
      edge_vec[NUM_SRC-1:0] = src_edge;
   end

   always_comb begin
      ack_mask = '0;
      if (irq_ack_i && (int'(irq_ack_id_i) < NUM_SRC)) ack_mask[irq_ack_id_i] = 1'b1;
   end

   // Apply lowest priority first so later terms win: clear, then SW set, then HW edge.
   always_comb begin
      ipr_nxt = ipr;
      epr_nxt = epr;
      if (wr_en && reg_idx == REG_ICP) ipr_nxt = ipr_nxt & ~wdata;
      if (wr_en && reg_idx == REG_ECP) epr_nxt = epr_nxt & ~wdata;
      ipr_nxt = ipr_nxt & ~ack_mask;
      if (wr_en && reg_idx == REG_IPR) ipr_nxt = ipr_nxt | wdata;
      ipr_nxt = ipr_nxt | edge_vec;
      epr_nxt = epr_nxt | edge_vec;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ier <= '0;
         ipr <= '0;
         eer <= '0;
         epr <= '0;
      end else begin
         ipr <= ipr_nxt;
         epr <= epr_nxt;
         if (wr_en && reg_idx == REG_IER) ier <= wdata;
         if (wr_en && reg_idx == REG_EER) eer <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_idx)
         REG_IER: rdata = ier;
         REG_IPR: rdata = ipr;
         REG_EER: rdata = eer;
         REG_EPR: rdata = epr;
         default: rdata = '0;
      endcase
   end

   assign apb.PRDATA  = rd_en ? rdata : '0;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = 1'b0;

   assign irq_o    = |(ipr & ier);
   assign irq_id_o = lowest_set_idx(ipr & ier);
   assign event_o  = |(epr & eer);

endmodule

// File: tb/tb_event_irq_ctrl.sv
// Self-checking bench for event_irq_ctrl: directed steps plus a randomized phase
// compared against a behavioural model of the pending/enable registers.
module tb_event_irq_ctrl;

   localparam int AW   = 12;
   localparam int NSRC = 24;
`ifdef EVENT_IRQ_SYNC_EN
   localparam int LAT  = 3;
   localparam bit SYNC = 1'b1;
`else
   localparam int LAT  = 1;
   localparam bit SYNC = 1'b0;
`endif
   localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - NSRC);

   logic            HCLK = 1'b0;
   logic            HRESET;
   logic [NSRC-1:0] src_i;
   logic            irq_ack_i;
   logic [4:0]      irq_ack_id_i;
   logic            irq_o;
   logic [4:0]      irq_id_o;
   logic            event_o;

   event_irq_ctrl_if #(.APB_ADDR_WIDTH(AW)) apb ();

   event_irq_ctrl #(.APB_ADDR_WIDTH(AW), .NUM_SRC(NSRC)) dut (
      .HCLK         (HCLK),
      .HRESET       (HRESET),
      .apb          (apb.slave),
      .src_i        (src_i),
      .irq_ack_i    (irq_ack_i),
      .irq_ack_id_i (irq_ack_id_i),
      .irq_o        (irq_o),
      .irq_id_o     (irq_id_o),
      .event_o      (event_o)
   );

   always #5 HCLK = ~HCLK;

   int checks = 0;
   int errors = 0;

   // Model state: what software would see in each register, plus the source history.
   logic [31:0] m_ier, m_ipr, m_eer, m_epr, m_prev, m_dly0, m_dly1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lowest(input logic [31:0] v);
      for (int k = 0; k < 32; k++) if (v[k]) return 32'(k);
      return 32'd0;
   endfunction

   function automatic logic [31:0] exp_read(input logic [2:0] idx);
      case (idx)
         3'd0: return m_ier;
         3'd1: return m_ipr;
         3'd3: return m_eer;
         3'd4: return m_epr;
         default: return 32'd0;
      endcase
   endfunction

   // Apply the register rules for the inputs seen at this clock edge.
   task automatic model_edge();
      logic [31:0] s, eff, rises, d, clr_i, clr_e, set_i;
      logic [2:0]  idx;
      logic        wr;
      s = 32'(src_i);
      if (HRESET) begin
         m_ier = 0; m_ipr = 0; m_eer = 0; m_epr = 0;
         m_prev = 0; m_dly0 = 0; m_dly1 = 0;
         return;
      end
      eff    = SYNC ? m_dly1 : s;
      m_dly1 = m_dly0;
      m_dly0 = s;
      rises  = eff & ~m_prev;
      m_prev = eff;
      wr  = apb.PSEL && apb.PENABLE && apb.PWRITE;
      idx = apb.PADDR[4:2];
      d   = apb.PWDATA & MASK;
      clr_i = (wr && idx == 3'd2) ? d : 32'd0;
      if (irq_ack_i && irq_ack_id_i < NSRC) clr_i[irq_ack_id_i] = 1'b1;
      clr_e = (wr && idx == 3'd5) ? d : 32'd0;
      set_i = (wr && idx == 3'd1) ? d : 32'd0;
      m_ipr = (m_ipr & ~clr_i) | set_i | rises;
      m_epr = (m_epr & ~clr_e) | rises;
      if (wr && idx == 3'd0) m_ier = d;
      if (wr && idx == 3'd3) m_eer = d;
   endtask

   task automatic check_outputs();
      chk("irq_o",    32'(irq_o),    32'(|(m_ipr & m_ier)));
      chk("irq_id_o", 32'(irq_id_o), lowest(m_ipr & m_ier));
      chk("event_o",  32'(event_o),  32'(|(m_epr & m_eer)));
      chk("PREADY",   32'(apb.PREADY),  32'd1);
      chk("PSLVERR",  32'(apb.PSLVERR), 32'd0);
   endtask

   task automatic tick();
      @(posedge HCLK);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic apb_setup(input logic [2:0] idx, input logic wr, input logic [31:0] data);
      apb.PSEL    = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = wr;
      apb.PADDR   = {7'($urandom), idx, 2'b00};
      apb.PWDATA  = data;
   endtask

   task automatic apb_idle();
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
   endtask

   task automatic apb_write(input logic [2:0] idx, input logic [31:0] data);
      apb_setup(idx, 1'b1, data);
      #1 chk("PRDATA_setup_wr", apb.PRDATA, 32'd0);
      tick();
      apb.PENABLE = 1'b1;
      #1 chk("PRDATA_access_wr", apb.PRDATA, 32'd0);
      tick();
      apb_idle();
   endtask

   task automatic apb_read(input logic [2:0] idx);
      apb_setup(idx, 1'b0, 32'($urandom));
      #1 chk("PRDATA_setup_rd", apb.PRDATA, 32'd0);
      tick();
      apb.PENABLE = 1'b1;
      #1 chk($sformatf("PRDATA_reg%0d", idx), apb.PRDATA, exp_read(idx));
      tick();
      apb_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      HRESET = 1'b1;
      src_i = '0;
      irq_ack_i = 1'b0;
      irq_ack_id_i = '0;
      apb.PADDR = '0;
      apb.PWDATA = '0;
      apb_idle();
      m_ier = 0; m_ipr = 0; m_eer = 0; m_epr = 0; m_prev = 0; m_dly0 = 0; m_dly1 = 0;
      #1;
      tick();
      tick();
      chk("reset_irq_o",    32'(irq_o),    32'd0);
      chk("reset_irq_id_o", 32'(irq_id_o), 32'd0);
      chk("reset_event_o",  32'(event_o),  32'd0);
      HRESET = 1'b0;
      tick();
      apb_read(3'd0);
      apb_read(3'd1);

      // Single-cycle pulse on source 3, IRQ enabled, event masked.
      apb_write(3'd0, 32'h8);
      apb_write(3'd3, 32'h0);
      src_i[3] = 1'b1;
      tick();
      src_i[3] = 1'b0;
      repeat (LAT - 1) tick();
      chk("pulse3_irq_o",    32'(irq_o),    32'd1);
      chk("pulse3_irq_id_o", 32'(irq_id_o), 32'd3);
      chk("pulse3_event_o",  32'(event_o),  32'd0);
      apb_read(3'd1);
      apb_read(3'd4);

      // Two simultaneous sources, acknowledged in priority order.
      apb_write(3'd2, 32'hFFFF_FFFF);
      apb_write(3'd5, 32'hFFFF_FFFF);
      apb_write(3'd0, 32'hFFFF_FFFF);
      src_i[7] = 1'b1;
      src_i[2] = 1'b1;
      repeat (LAT) tick();
      chk("dual_id_first", 32'(irq_id_o), 32'd2);
      irq_ack_i = 1'b1;
      irq_ack_id_i = 5'd2;
      tick();
      irq_ack_i = 1'b0;
      chk("dual_id_second", 32'(irq_id_o), 32'd7);
      irq_ack_i = 1'b1;
      irq_ack_id_i = 5'd7;
      tick();
      irq_ack_i = 1'b0;
      chk("dual_irq_done", 32'(irq_o), 32'd0);
      src_i = '0;
      tick();

      // Event clear colliding with a fresh edge on the same source.
      apb_write(3'd3, 32'h1);
      src_i[0] = 1'b1;
      repeat (LAT) tick();
      chk("evt0_event_o", 32'(event_o), 32'd1);
      src_i[0] = 1'b0;
      tick();
      apb_setup(3'd5, 1'b1, 32'h1);
      repeat (LAT) tick();
      apb.PENABLE = 1'b1;
      src_i[0] = 1'b1;
      if (SYNC) begin
         // Align the clear with the edge arriving through the synchroniser.
         apb.PENABLE = 1'b0;
         repeat (LAT - 1) tick();
         apb.PENABLE = 1'b1;
      end
      tick();
      apb_idle();
      chk("ecp_vs_edge_event_o", 32'(event_o), 32'd1);
      apb_read(3'd4);
      src_i[0] = 1'b0;
      tick();

      // Held source: cleared once, must not re-set until it falls and rises.
      apb_write(3'd2, 32'hFFFF_FFFF);
      apb_write(3'd5, 32'hFFFF_FFFF);
      src_i[5] = 1'b1;
      repeat (LAT + 2) tick();
      chk("hold5_set", 32'(irq_id_o), 32'd5);
      apb_write(3'd2, 32'h20);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold5_no_reset", 32'(irq_o), 32'd0);
      end
      src_i[5] = 1'b0;
      tick();
      src_i[5] = 1'b1;
      repeat (LAT) tick();
      chk("hold5_rearm_irq", 32'(irq_o), 32'd1);
      chk("hold5_rearm_id",  32'(irq_id_o), 32'd5);
      src_i = '0;
      tick();

      // Software-set IRQ and reserved/clear register reads.
      apb_write(3'd2, 32'hFFFF_FFFF);
      apb_write(3'd0, 32'h10);
      apb_write(3'd1, 32'h10);
      chk("swset_irq_o",    32'(irq_o),    32'd1);
      chk("swset_irq_id_o", 32'(irq_id_o), 32'd4);
      apb_read(3'd2);
      apb_read(3'd5);
      apb_read(3'd6);
      apb_read(3'd7);

      // Bits at and above NUM_SRC, and out-of-range acknowledge ids.
      apb_write(3'd0, 32'hFFFF_FFFF);
      apb_read(3'd0);
      apb_write(3'd1, 32'hFFFF_FFFF);
      apb_read(3'd1);
      irq_ack_i = 1'b1;
      irq_ack_id_i = 5'(NSRC);
      tick();
      irq_ack_id_i = 5'd31;
      tick();
      irq_ack_i = 1'b0;
      apb_read(3'd1);
      apb_write(3'd2, 32'hFFFF_FFFF);
      apb_write(3'd5, 32'hFFFF_FFFF);

      // Edge-to-irq_o latency.
      tick();
      src_i[1] = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n++;
         if (irq_o) break;
      end
      chk("latency_cycles", 32'(n), 32'(LAT));

      // Reset during a write access, then a source already high at release.
      src_i[9] = 1'b1;
      apb_setup(3'd0, 1'b1, 32'h0000_0200);
      tick();
      apb.PENABLE = 1'b1;
      HRESET = 1'b1;
      tick();
      apb_idle();
      chk("rst_mid_irq_o",    32'(irq_o),    32'd0);
      chk("rst_mid_irq_id_o", 32'(irq_id_o), 32'd0);
      chk("rst_mid_event_o",  32'(event_o),  32'd0);
      HRESET = 1'b0;
      repeat (LAT) tick();
      apb_read(3'd0);
      apb_read(3'd1);
      apb_read(3'd4);

      // Randomized traffic.
      for (int it = 0; it < 300; it++) begin
         src_i = src_i ^ NSRC'($urandom & $urandom & $urandom);
         irq_ack_i = ($urandom_range(0, 3) == 0);
         irq_ack_id_i = ($urandom_range(0, 1) == 0) ? 5'(lowest(m_ipr & m_ier)) : 5'($urandom_range(0, 31));
         case ($urandom_range(0, 6))
            0, 1: tick();
            2: apb_write(3'($urandom_range(0, 7)), $urandom);
            3: apb_read(3'($urandom_range(0, 7)));
            4: apb_write(($urandom_range(0, 1) == 0) ? 3'd2 : 3'd5, $urandom & $urandom);
            5: apb_write(($urandom_range(0, 1) == 0) ? 3'd0 : 3'd3, $urandom | $urandom);
            default: apb_read(($urandom_range(0, 1) == 0) ? 3'd1 : 3'd4);
         endcase
      end
      irq_ack_i = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
